// File: rtl/program_counter.sv
// Architectural PC register for the RV32I core: loads NextPC every rising edge, RESET_VECTOR on reset.
// Optional PC_MISALIGN_EN macro adds a registered instruction-address-misaligned flag.
module program_counter #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] NextPC,
  output logic [WIDTH-1:0] PC
`ifdef PC_MISALIGN_EN
  ,
  output logic             misaligned
`endif
);

  always_ff @(posedge clk) begin
    if (reset) PC <= RESET_VECTOR;
    else       PC <= NextPC;
  end

`ifdef PC_MISALIGN_EN
  // Computed from the value being loaded so the flag tracks PC with no extra delay; held low after reset.
  always_ff @(posedge clk) begin
    if (reset) misaligned <= 1'b0;
    else       misaligned <= |NextPC[1:0];
  end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed spec scenarios plus randomized traffic
// checked every cycle against a behavioural model (also covers PC_MISALIGN_EN when defined).
module tb_program_counter;

  localparam int          WIDTH = 32;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] NextPC;
  logic [WIDTH-1:0] PC;
`ifdef PC_MISALIGN_EN
  logic             misaligned;
`endif

  int checks = 0;
  int errors = 0;

  program_counter #(.WIDTH(WIDTH), .RESET_VECTOR(RV)) dut (
    .clk    (clk),
    .reset  (reset),
    .NextPC (NextPC),
    .PC     (PC)
`ifdef PC_MISALIGN_EN
    ,
    .misaligned (misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: after an edge, PC is whatever the inputs asked for at that edge.
  logic [31:0] exp_pc;
  bit          exp_valid = 1'b0;
  bit          exp_reset_last = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      exp_pc         = RV;
      exp_valid      = 1'b1;
      exp_reset_last = 1'b1;
    end else if (exp_valid) begin
      exp_pc         = NextPC;
      exp_reset_last = 1'b0;
    end
  end

  // Snapshot shortly after each edge to prove PC does not move until the next edge.
  logic [31:0] mid_pc;
  always @(posedge clk) begin
    #2 mid_pc = PC;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (PC !== exp_pc) begin
        errors++;
        $display("[TB] FAIL model_pc t=%0t actual=%h required=%h", $time, PC, exp_pc);
      end
      checks++;
      if (PC !== mid_pc) begin
        errors++;
        $display("[TB] FAIL pc_stable t=%0t actual=%h required=%h", $time, PC, mid_pc);
      end
`ifdef PC_MISALIGN_EN
      checks++;
      if (misaligned !== (exp_reset_last ? 1'b0 : (exp_pc[1:0] != 2'b00))) begin
        errors++;
        $display("[TB] FAIL model_misaligned t=%0t actual=%b pc=%h", $time, misaligned, exp_pc);
      end
`endif
    end
  end

  task automatic applyStimulus(input logic r, input logic [31:0] nxt);
    reset  = r;
    NextPC = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] required);
    checks++;
    if (PC !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, PC, required);
    end
  endtask

`ifdef PC_MISALIGN_EN
  task automatic checkMisaligned(input string name, input logic required);
    checks++;
    if (misaligned !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%b required=%b", name, misaligned, required);
    end
  endtask
`endif

  initial begin
    reset  = 1'b1;
    NextPC = 32'h0000_000C;

    applyStimulus(1'b1, 32'h0000_000C); checkOutput("reset_ignores_next", 32'h0000_0000);
    applyStimulus(1'b0, 32'h0000_0004); checkOutput("seq_4", 32'h0000_0004);
    applyStimulus(1'b0, 32'h0000_0008); checkOutput("seq_8", 32'h0000_0008);
    applyStimulus(1'b0, 32'h0000_000C); checkOutput("seq_C", 32'h0000_000C);
    applyStimulus(1'b0, 32'h1000_0000); checkOutput("jump", 32'h1000_0000);
    applyStimulus(1'b0, 32'h1000_0004); checkOutput("jump_plus4", 32'h1000_0004);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h1000_0004); checkOutput("hold", 32'h1000_0004);
    end
    applyStimulus(1'b1, 32'h0000_0020); checkOutput("midrun_reset", 32'h0000_0000);
`ifdef PC_MISALIGN_EN
    checkMisaligned("mis_after_reset", 1'b0);
`endif
    applyStimulus(1'b0, 32'h0000_0004); checkOutput("resume_after_reset", 32'h0000_0004);
    applyStimulus(1'b0, 32'h0000_0006); checkOutput("no_low_bit_mask", 32'h0000_0006);
`ifdef PC_MISALIGN_EN
    checkMisaligned("mis_set", 1'b1);
`endif
    applyStimulus(1'b0, 32'h0000_0008); checkOutput("aligned_again", 32'h0000_0008);
`ifdef PC_MISALIGN_EN
    checkMisaligned("mis_clear", 1'b0);
`endif
    applyStimulus(1'b0, 32'hFFFF_FFFF); checkOutput("all_ones", 32'hFFFF_FFFF);
    applyStimulus(1'b1, 32'hFFFF_FFFF); checkOutput("reset_dominates", 32'h0000_0000);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(15) == 0), $urandom);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
